// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD registered read ports, two write ports, virtual PC.
// Contents are loaded by a post-reset sweep before ready rises.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 3,
    parameter int PC_IDX = 15,
    parameter int PC_OFFSET = 8,
    parameter int SP_IDX = 13,
    parameter logic [DATA_W-1:0] SP_INIT = 32'h0001_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic [DATA_W-1:0]        pc_in,
    output logic                     ready,
    output logic                     pc_wr_valid,
    output logic [DATA_W-1:0]        pc_wr_data
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] PC_A   = ADDR_W'(PC_IDX);
    localparam logic [ADDR_W-1:0] SP_A   = ADDR_W'(SP_IDX);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] PC_OFF = DATA_W'(PC_OFFSET);

    typedef enum logic {INIT, RUN} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] cnt, cnt_next;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_next [NUM_RD];
    logic              run;
    logic              wr0, wr1, pc_hit0, pc_hit1;

    assign run     = (state == RUN);
    assign ready   = run;
    assign pc_hit0 = run && we0 && (wa0 == PC_A);
    assign pc_hit1 = run && we1 && (wa1 == PC_A);
    assign wr0     = run && we0 && (wa0 != PC_A);
    // Port 1 yields to port 0 on an address collision.
    assign wr1     = run && we1 && (wa1 != PC_A) && !(we0 && (wa0 == wa1));

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (state == INIT) begin
            cnt_next = cnt + ADDR_W'(1);
            if (cnt == LAST_A)
                state_next = RUN;
        end
    end

    // Read data: virtual PC first, then write-first bypass (port 0 priority), then storage.
    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            rd_next[k] = '0;
            if (run) begin
                if (ra[k*ADDR_W +: ADDR_W] == PC_A)
                    rd_next[k] = pc_in + PC_OFF;
                else if (we0 && (wa0 == ra[k*ADDR_W +: ADDR_W]))
                    rd_next[k] = wd0;
                else if (we1 && (wa1 == ra[k*ADDR_W +: ADDR_W]))
                    rd_next[k] = wd1;
                else
                    rd_next[k] = mem[ra[k*ADDR_W +: ADDR_W]];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= INIT;
            cnt         <= '0;
            rd          <= '0;
            pc_wr_valid <= 1'b0;
            pc_wr_data  <= '0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            pc_wr_valid <= pc_hit0 || pc_hit1;
            if (pc_hit0)
                pc_wr_data <= wd0;
            else if (pc_hit1)
                pc_wr_data <= wd1;
            for (int k = 0; k < NUM_RD; k++)
                rd[k*DATA_W +: DATA_W] <= rd_next[k];
        end
    end

    // Storage has no reset; the INIT sweep gives it defined contents.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            if (cnt != PC_A)
                mem[cnt] <= (cnt == SP_A) ? SP_INIT : '0;
        end else begin
            if (wr1)
                mem[wa1] <= wd1;
            if (wr0)
                mem[wa0] <= wd0;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed checks of regfile_mp against an array-based model of the
// register file rules (init values, write priority, bypass, virtual PC).
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] ra;
    logic [95:0] rd;
    logic        we0, we1;
    logic [3:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [31:0] pc_in;
    logic        ready;
    logic        pc_wr_valid;
    logic [31:0] pc_wr_data;

    int testsRun = 0;
    int testsFailed = 0;

    logic [31:0] model [16];
    bit          modelRun;
    int          initCycles;

    regfile_mp dut (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .pc_in(pc_in), .ready(ready),
        .pc_wr_valid(pc_wr_valid), .pc_wr_data(pc_wr_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, predict outputs from the model, check after the edge.
    task automatic applyStimulus(input bit w0, input logic [3:0] a0, input logic [31:0] d0,
                                 input bit w1, input logic [3:0] a1, input logic [31:0] d1,
                                 input logic [3:0] r0, input logic [3:0] r1, input logic [3:0] r2,
                                 input logic [31:0] pc);
        logic [3:0]  rAddr [3];
        logic [31:0] expRd [3];
        bit          expValid;
        logic [31:0] expData;
        we0 = w0; wa0 = a0; wd0 = d0;
        we1 = w1; wa1 = a1; wd1 = d1;
        ra = {r2, r1, r0};
        pc_in = pc;
        rAddr[0] = r0; rAddr[1] = r1; rAddr[2] = r2;
        for (int k = 0; k < 3; k++) begin
            if (!modelRun)
                expRd[k] = 32'd0;
            else if (rAddr[k] == 4'd15)
                expRd[k] = pc + 32'd8;
            else if (w0 && a0 == rAddr[k])
                expRd[k] = d0;
            else if (w1 && a1 == rAddr[k])
                expRd[k] = d1;
            else
                expRd[k] = model[rAddr[k]];
        end
        expValid = modelRun && ((w0 && a0 == 4'd15) || (w1 && a1 == 4'd15));
        expData = (w0 && a0 == 4'd15) ? d0 : d1;
        if (modelRun) begin
            if (w1 && a1 != 4'd15) model[a1] = d1;
            if (w0 && a0 != 4'd15) model[a0] = d0;
        end else begin
            initCycles++;
            if (initCycles == 16) begin
                modelRun = 1'b1;
                for (int i = 0; i < 16; i++)
                    model[i] = (i == 13) ? 32'h0001_0000 : 32'd0;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++)
            checkOutput($sformatf("rd%0d(r%0d)", k, rAddr[k]), rd[k*32 +: 32], expRd[k]);
        checkOutput("ready", {31'd0, ready}, {31'd0, modelRun});
        checkOutput("pc_wr_valid", {31'd0, pc_wr_valid}, {31'd0, expValid});
        if (expValid)
            checkOutput("pc_wr_data", pc_wr_data, expData);
    endtask

    task automatic idle(input logic [3:0] r0, input logic [3:0] r1, input logic [3:0] r2,
                        input logic [31:0] pc);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, r0, r1, r2, pc);
    endtask

    // Reset is asynchronous: outputs must clear before any clock edge.
    task automatic doReset();
        we0 = 1'b0; we1 = 1'b0;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++)
            checkOutput($sformatf("rst_rd%0d", k), rd[k*32 +: 32], 32'd0);
        checkOutput("rst_ready", {31'd0, ready}, 32'd0);
        checkOutput("rst_pc_wr_valid", {31'd0, pc_wr_valid}, 32'd0);
        checkOutput("rst_pc_wr_data", pc_wr_data, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelRun = 1'b0;
        initCycles = 0;
    endtask

    initial begin
        logic [3:0]  a0, a1;
        logic [31:0] pc;
        rst = 1'b1;
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        ra = '0; pc_in = '0;
        modelRun = 1'b0;
        initCycles = 0;
        doReset();

        // INIT phase, with writes (including to PC) that must be dropped.
        for (int i = 0; i < 16; i++) begin
            if (i == 3)
                applyStimulus(1'b1, 4'd2, 32'h55, 1'b0, 4'd0, 32'd0, 4'd2, 4'd13, 4'd15, 32'h100);
            else if (i == 5)
                applyStimulus(1'b1, 4'd15, 32'h99, 1'b1, 4'd15, 32'h98, 4'd0, 4'd2, 4'd15, 32'h100);
            else
                idle(4'(i), 4'd13, 4'd15, 32'h100);
        end

        idle(4'd13, 4'd0, 4'd7, 32'h0);
        idle(4'd12, 4'd2, 4'd13, 32'h0);

        applyStimulus(1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 4'd0, 32'h0);
        idle(4'd3, 4'd3, 4'd3, 32'h0);

        applyStimulus(1'b1, 4'd5, 32'h11, 1'b1, 4'd5, 32'h22, 4'd0, 4'd5, 4'd1, 32'h0);
        idle(4'd5, 4'd5, 4'd5, 32'h0);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 32'h33, 4'd6, 4'd0, 4'd0, 32'h0);
        idle(4'd6, 4'd5, 4'd3, 32'h0);

        idle(4'd15, 4'd15, 4'd13, 32'h100);
        idle(4'd15, 4'd0, 4'd15, 32'hFFFF_FFFC);
        applyStimulus(1'b1, 4'd15, 32'h200, 1'b0, 4'd0, 32'd0, 4'd15, 4'd1, 4'd2, 32'h300);
        idle(4'd15, 4'd2, 4'd3, 32'h300);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd15, 32'h444, 4'd15, 4'd15, 4'd15, 32'h10);
        applyStimulus(1'b1, 4'd15, 32'h555, 1'b1, 4'd15, 32'h666, 4'd1, 4'd2, 4'd3, 32'h10);

        // Mid-run reset while pc_wr_valid and rd are non-zero.
        applyStimulus(1'b1, 4'd4, 32'h77, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 4'd0, 32'h0);
        applyStimulus(1'b1, 4'd15, 32'h123, 1'b0, 4'd0, 32'd0, 4'd4, 4'd15, 4'd3, 32'h40);
        doReset();
        for (int i = 0; i < 16; i++)
            idle(4'd4, 4'd13, 4'd15, 32'h0);
        idle(4'd4, 4'd3, 4'd13, 32'h0);

        for (int i = 0; i < 400; i++) begin
            a0 = 4'($urandom_range(0, 15));
            a1 = ($urandom_range(0, 3) == 0) ? a0 : 4'($urandom_range(0, 15));
            pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF8 + 32'($urandom_range(0, 7))) : $urandom;
            applyStimulus(1'($urandom_range(0, 1)), a0, $urandom,
                          1'($urandom_range(0, 1)), a1, $urandom,
                          ($urandom_range(0, 2) == 0) ? a0 : 4'($urandom_range(0, 15)),
                          ($urandom_range(0, 2) == 0) ? a1 : 4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)), pc);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
